// File: rtl/spi_xfer_seq_pkg.sv
// Shared types and constants for the SPI multi-word transfer sequencer.
// Holds the sequencer state encoding, the default geometry used as the top
// level parameter defaults, and the fixed engine byte-select value.
package spi_xfer_seq_pkg;

  localparam int unsigned SPI_SEQ_DW    = 32;  // equals the engine max char width
  localparam int unsigned SPI_SEQ_CNT_W = 16;
  localparam int unsigned SPI_SEQ_DLY_W = 8;
  localparam int unsigned SPI_SEQ_SS_W  = 8;

  // The engine always moves a full word, so all byte lanes are enabled.
  localparam logic [3:0] SPI_SEQ_BYTE_SEL_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_GO     = 3'd3,
    ST_WAITHI = 3'd4,
    ST_XFER   = 3'd5,
    ST_HOLD   = 3'd6
  } seq_state_t;

endpackage

// File: rtl/spi_xfer_seq_cs_timer.sv
// Loadable down-counter with a zero flag, used to time both the slave-select
// setup delay (before the first word) and the hold delay (after the last one).
// Ports:
//   clk, rst     clock, async active-high reset
//   i_load       load i_load_val (has priority over decrement)
//   i_load_val   value to load
//   i_dec        decrement by one; saturates at zero, never wraps
//   o_zero       counter is zero
module spi_xfer_seq_cs_timer #(
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DLY_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [DLY_W-1:0] r_cnt;

  // NOTE: clocked state is only ever assigned with <= so every register in the
  // design samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/spi_xfer_seq.sv
// Multi-word transfer sequencer placed between the bus-register front end and
// the SPI shift engine. A burst of nwords words is pulled from a valid/ready TX
// stream; each word is latched into the engine, started with a go pulse, and
// the received word is offered on a valid/ready RX stream. Slave select is
// asserted for cs_setup+1 cycles before the first latch and held for
// cs_hold+1 cycles after the last capture.
// Ports:
//   clk, rst                 clock, async active-high reset (shared with engine)
//   start, abort             1-cycle control pulses
//   nwords/ss_sel/cs_setup/cs_hold  burst configuration, sampled on start
//   tx_data/tx_valid/tx_ready       TX word stream
//   rx_data/rx_valid/rx_ready       RX word stream (rx_valid held until ready)
//   busy, done, aborted      status: not idle, end-of-burst pulse, sticky abort
//   ss_n                     active-low slave selects
//   sh_latch/sh_byte_sel/sh_p_in/sh_go  engine load and start controls
//   sh_tip/sh_p_out          engine transfer-in-progress and received word
module spi_xfer_seq
  import spi_xfer_seq_pkg::*;
#(
  parameter int DW    = SPI_SEQ_DW,
  parameter int CNT_W = SPI_SEQ_CNT_W,
  parameter int DLY_W = SPI_SEQ_DLY_W,
  parameter int SS_W  = SPI_SEQ_SS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] nwords,
  input  logic [SS_W-1:0]  ss_sel,
  input  logic [DLY_W-1:0] cs_setup,
  input  logic [DLY_W-1:0] cs_hold,
  input  logic [DW-1:0]    tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [DW-1:0]    rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [SS_W-1:0]  ss_n,
  output logic             sh_latch,
  output logic [3:0]       sh_byte_sel,
  output logic [DW-1:0]    sh_p_in,
  output logic             sh_go,
  input  logic             sh_tip,
  input  logic [DW-1:0]    sh_p_out
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [CNT_W-1:0] r_rem;
  logic [DLY_W-1:0] r_hold_cfg;
  logic [SS_W-1:0]  r_ss_n;
  logic [DW-1:0]    r_rx_data;
  logic [DW-1:0]    r_sh_p_in;
  logic             r_rx_valid;
  logic             r_abort_pend;
  logic             r_aborted;
  logic             r_done;

  logic             w_start_ok;
  logic             w_abort_now;
  logic             w_accept;
  logic             w_capture;
  logic             w_hold_exit;
  logic             w_dly_load;
  logic             w_dly_dec;
  logic [DLY_W-1:0] w_dly_val;
  logic             w_dly_zero;

  // A start with an empty burst is treated as if it never happened.
  assign w_start_ok  = (r_state == ST_IDLE) && start && (nwords != '0);
  // An abort arriving this very cycle acts like one already pending.
  assign w_abort_now = abort || r_abort_pend;

  spi_xfer_seq_cs_timer #(
    .DLY_W(DLY_W)
  ) u_cs_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_dly_load),
    .i_load_val(w_dly_val),
    .i_dec     (w_dly_dec),
    .o_zero    (w_dly_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_hold_exit = 1'b0;
    w_dly_load  = 1'b0;
    w_dly_dec   = 1'b0;
    w_dly_val   = r_hold_cfg;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_next     = ST_SETUP;
          w_dly_load = 1'b1;
          w_dly_val  = cs_setup;
        end
      end
      ST_SETUP: begin
        if (w_abort_now) begin
          w_next     = ST_HOLD;
          w_dly_load = 1'b1;
        end else if (w_dly_zero) begin
          w_next = ST_LOAD;
        end else begin
          w_dly_dec = 1'b1;
        end
      end
      ST_LOAD: begin
        // Only reached with the engine idle, so latching here is always safe.
        if (w_abort_now) begin
          w_next     = ST_HOLD;
          w_dly_load = 1'b1;
        end else if (tx_valid) begin
          w_accept = 1'b1;
          w_next   = ST_GO;
        end
      end
      ST_GO: begin
        w_next = ST_WAITHI;
      end
      ST_WAITHI: begin
        if (sh_tip) begin
          w_next = ST_XFER;
        end
      end
      ST_XFER: begin
        // Capture only into an empty RX slot; otherwise stall here so the
        // received word is never overwritten.
        if (!sh_tip && !r_rx_valid) begin
          w_capture = 1'b1;
          if ((r_rem != '0) && !w_abort_now) begin
            w_next = ST_LOAD;
          end else begin
            w_next     = ST_HOLD;
            w_dly_load = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_dly_zero) begin
          w_next      = ST_IDLE;
          w_hold_exit = 1'b1;
        end else begin
          w_dly_dec = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem        <= '0;
      r_hold_cfg   <= '0;
      r_ss_n       <= '1;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_sh_p_in    <= '0;
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_hold_exit;

      if (w_start_ok) begin
        r_rem        <= nwords;
        r_hold_cfg   <= cs_hold;
        r_ss_n       <= ~ss_sel;
        r_abort_pend <= 1'b0;
        r_aborted    <= 1'b0;
      end else begin
        if (w_accept && (r_rem != '0)) begin
          r_rem <= r_rem - 1'b1;
        end
        if (w_hold_exit) begin
          r_ss_n <= '1;
        end
        if (abort && (r_state != ST_IDLE)) begin
          r_abort_pend <= 1'b1;
          r_aborted    <= 1'b1;
        end
      end

      if (w_accept) begin
        r_sh_p_in <= tx_data;
      end

      // A capture outranks a same-cycle consumer handshake.
      if (w_capture) begin
        r_rx_data  <= sh_p_out;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign tx_ready    = w_accept;
  assign sh_latch    = w_accept;
  assign sh_go       = (r_state == ST_GO);
  assign sh_p_in     = r_sh_p_in;
  assign sh_byte_sel = SPI_SEQ_BYTE_SEL_ALL;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign ss_n        = r_ss_n;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Self-checking bench for spi_xfer_seq. A behavioural SPI engine loops the
// latched word back after a random delay; a TX source feeds words from a queue
// and an RX sink collects accepted words. Each burst's expectations (word
// order, number of go pulses, done count, slave-select and delay timing) come
// from the burst description, not from the DUT.
module tb_spi_xfer_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] nwords;
  logic [7:0]  ss_sel;
  logic [7:0]  cs_setup;
  logic [7:0]  cs_hold;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  ss_n;
  logic        sh_latch;
  logic [3:0]  sh_byte_sel;
  logic [31:0] sh_p_in;
  logic        sh_go;
  logic        sh_tip;
  logic [31:0] sh_p_out;

  int checks = 0;
  int errors = 0;

  spi_xfer_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .nwords(nwords),
    .ss_sel(ss_sel), .cs_setup(cs_setup), .cs_hold(cs_hold),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .aborted(aborted), .ss_n(ss_n),
    .sh_latch(sh_latch), .sh_byte_sel(sh_byte_sel), .sh_p_in(sh_p_in),
    .sh_go(sh_go), .sh_tip(sh_tip), .sh_p_out(sh_p_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural engine: loopback with random latency -------
  int          eng_phase;
  int          eng_cnt;
  logic [31:0] eng_word;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_tip    <= 1'b0;
      sh_p_out  <= '0;
      eng_phase <= 0;
      eng_cnt   <= 0;
      eng_word  <= '0;
    end else begin
      case (eng_phase)
        0: if (sh_go) begin
          eng_word  <= sh_p_in;
          eng_cnt   <= int'($urandom_range(0, 2));
          eng_phase <= 1;
        end
        1: if (eng_cnt == 0) begin
          sh_tip    <= 1'b1;
          eng_cnt   <= int'($urandom_range(1, 6));
          eng_phase <= 2;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
        default: if (eng_cnt == 0) begin
          sh_tip    <= 1'b0;
          sh_p_out  <= eng_word;
          eng_phase <= 0;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      endcase
    end
  end

  // ---------------- TX source ----------------------------------------------
  logic [31:0] tx_q[$];
  logic        tx_en = 1'b1;

  initial begin
    logic acc;
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge clk);
      acc = tx_valid && tx_ready;
      @(posedge clk);
      #1;
      if (acc && (tx_q.size() > 0)) void'(tx_q.pop_front());
      tx_valid = tx_en && (tx_q.size() > 0);
      tx_data  = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
    end
  end

  // ---------------- RX sink: 0 = never ready, 1 = always, 2 = random --------
  int rx_mode = 1;

  initial begin
    rx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rx_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        default: rx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- observation (sampled on the falling edge) --------------
  int          ncyc = 0;
  int          go_cnt, done_cnt, ss_bad;
  int          ss_fall_cyc, ss_rise_cyc, first_latch_cyc, last_cap_cyc, done_cyc;
  logic        busy_seen;
  logic [7:0]  exp_ss = 8'hFF;
  logic [31:0] rx_got[$];

  task automatic clear_obs();
    go_cnt = 0; done_cnt = 0; ss_bad = 0; busy_seen = 1'b0;
    ss_fall_cyc = -1; ss_rise_cyc = -1; first_latch_cyc = -1;
    last_cap_cyc = -1; done_cyc = -1;
    rx_got.delete();
  endtask

  initial begin
    logic [7:0] prev_ss;
    logic       prev_rxv;
    prev_ss  = 8'hFF;
    prev_rxv = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (busy) busy_seen = 1'b1;
      if ((ss_n != 8'hFF) && (prev_ss == 8'hFF)) ss_fall_cyc = ncyc;
      if ((ss_n == 8'hFF) && (prev_ss != 8'hFF)) ss_rise_cyc = ncyc;
      if (busy && (ss_n != exp_ss)) ss_bad++;
      if (sh_latch && (first_latch_cyc < 0)) first_latch_cyc = ncyc;
      if (sh_go) go_cnt++;
      if (rx_valid && !prev_rxv) last_cap_cyc = ncyc;
      if (done) begin done_cnt++; done_cyc = ncyc; end
      if (rx_valid && rx_ready) rx_got.push_back(rx_data);
      prev_ss  = ss_n;
      prev_rxv = rx_valid;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic start_burst(input int n, input logic [7:0] sel,
                             input logic [7:0] su, input logic [7:0] ho);
    @(posedge clk);
    #1;
    nwords = 16'(n); ss_sel = sel; cs_setup = su; cs_hold = ho;
    exp_ss = ~sel;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!busy && !rx_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios -----------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; nwords = '0; ss_sel = '0;
    cs_setup = '0; cs_hold = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ss_n !== 8'hFF) begin errors++; $display("FAIL reset_ss_n got %h want ff", ss_n); end
    checks++;
    if ({tx_ready, rx_valid, sh_latch, sh_go, busy, done, aborted} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {tx_ready, rx_valid, sh_latch, sh_go, busy, done, aborted});
    end
    checks++;
    if ((rx_data !== 32'h0) || (sh_p_in !== 32'h0)) begin
      errors++; $display("FAIL reset_data got rx=%h p_in=%h want 0", rx_data, sh_p_in);
    end
    checks++;
    if (sh_byte_sel !== 4'hF) begin errors++; $display("FAIL byte_sel got %h want f", sh_byte_sel); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    clear_obs();
    rx_mode = 1;
    tx_q.push_back(32'hA5A5_0F0F);
    start_burst(1, 8'h04, 8'd2, 8'd3);
    wait_quiet(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got busy=%b want idle", busy); end
    checks++;
    if (first_latch_cyc - ss_fall_cyc !== 3) begin
      errors++; $display("FAIL single_setup got %0d want 3", first_latch_cyc - ss_fall_cyc);
    end
    checks++;
    if ((rx_got.size() != 1) || (rx_got[0] !== 32'hA5A5_0F0F)) begin
      errors++; $display("FAIL single_rx got n=%0d want a5a50f0f", rx_got.size());
    end
    checks++;
    if (done_cyc - last_cap_cyc !== 4) begin
      errors++; $display("FAIL single_hold got %0d want 4", done_cyc - last_cap_cyc);
    end
    checks++;
    if ((go_cnt !== 1) || (done_cnt !== 1) || (ss_rise_cyc !== done_cyc) || (ss_bad !== 0)) begin
      errors++;
      $display("FAIL single_ctl got go=%0d done=%0d rise=%0d done_at=%0d ssbad=%0d want 1 1 equal 0",
               go_cnt, done_cnt, ss_rise_cyc, done_cyc, ss_bad);
    end
  endtask

  task automatic test_burst();
    bit ok;
    for (int it = 0; it < 5; it++) begin
      logic [31:0] exp_q[$];
      int          n;
      logic [7:0]  sel, su, ho;
      clear_obs();
      if (it == 0) begin
        n = 3; sel = 8'h01; su = 8'd1; ho = 8'd1; rx_mode = 1;
        exp_q = '{32'd1, 32'd2, 32'd3};
      end else begin
        n = int'($urandom_range(2, 6));
        sel = 8'(1 << $urandom_range(0, 7));
        su = 8'($urandom_range(0, 4)); ho = 8'($urandom_range(0, 4));
        rx_mode = 2;
        for (int k = 0; k < n; k++) exp_q.push_back($urandom);
      end
      foreach (exp_q[k]) tx_q.push_back(exp_q[k]);
      start_burst(n, sel, su, ho);
      wait_quiet(1000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL burst%0d_timeout got busy=%b want idle", it, busy); end
      checks++;
      if ((go_cnt !== n) || (done_cnt !== 1) || (aborted !== 1'b0)) begin
        errors++;
        $display("FAIL burst%0d_ctl got go=%0d done=%0d aborted=%b want %0d 1 0",
                 it, go_cnt, done_cnt, aborted, n);
      end
      checks++;
      if (rx_got != exp_q) begin
        errors++; $display("FAIL burst%0d_rx got n=%0d want n=%0d in order", it, rx_got.size(), n);
      end
      checks++;
      if ((first_latch_cyc - ss_fall_cyc !== int'(su) + 1) ||
          (done_cyc - last_cap_cyc !== int'(ho) + 1) || (ss_bad !== 0)) begin
        errors++;
        $display("FAIL burst%0d_timing got setup=%0d hold=%0d ssbad=%0d want %0d %0d 0", it,
                 first_latch_cyc - ss_fall_cyc, done_cyc - last_cap_cyc, ss_bad, su + 1, ho + 1);
      end
    end
    rx_mode = 1;
  endtask

  task automatic test_rx_stall();
    bit          ok;
    logic [31:0] w0, w1;
    w0 = $urandom; w1 = $urandom;
    clear_obs();
    rx_mode = 0;
    tx_q.push_back(w0); tx_q.push_back(w1);
    start_burst(2, 8'h80, 8'd0, 8'd0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (rx_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_first got rx_valid=0 want 1"); end
    repeat (50) @(negedge clk);
    #1;
    checks++;
    if ((go_cnt !== 2) || (busy !== 1'b1) || (done_cnt !== 0) || (ss_n !== 8'h7F) ||
        (rx_data !== w0) || (rx_got.size() != 0)) begin
      errors++;
      $display("FAIL stall_hold got go=%0d busy=%b done=%0d ss=%h rx=%h want 2 1 0 7f %h",
               go_cnt, busy, done_cnt, ss_n, rx_data, w0);
    end
    rx_mode = 1;
    wait_quiet(200, ok);
    checks++;
    if (!ok || (rx_got.size() != 2) || (rx_got[0] !== w0) || (rx_got[1] !== w1) || (done_cnt !== 1)) begin
      errors++;
      $display("FAIL stall_drain got n=%0d done=%0d want 2 words %h %h and done=1",
               rx_got.size(), done_cnt, w0, w1);
    end
  endtask

  task automatic test_tx_gap();
    bit          ok;
    logic [31:0] w0, w1;
    w0 = $urandom; w1 = $urandom;
    clear_obs();
    rx_mode = 1;
    tx_q.push_back(w0);
    start_burst(2, 8'h10, 8'd1, 8'd2);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (rx_got.size() == 1) begin ok = 1'b1; break; end
    end
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (!ok || (go_cnt !== 1) || (busy !== 1'b1) || (ss_n !== 8'hEF) || (done_cnt !== 0)) begin
      errors++;
      $display("FAIL txgap_wait got go=%0d busy=%b ss=%h done=%0d want 1 1 ef 0",
               go_cnt, busy, ss_n, done_cnt);
    end
    tx_q.push_back(w1);
    wait_quiet(300, ok);
    checks++;
    if (!ok || (go_cnt !== 2) || (rx_got.size() != 2) || (rx_got[1] !== w1) || (done_cnt !== 1)) begin
      errors++;
      $display("FAIL txgap_resume got go=%0d n=%0d done=%0d want 2 2 1", go_cnt, rx_got.size(), done_cnt);
    end
  endtask

  task automatic test_abort();
    bit          ok;
    logic [31:0] exp_q[$];
    for (int k = 0; k < 4; k++) exp_q.push_back($urandom);
    clear_obs();
    rx_mode = 1;
    foreach (exp_q[k]) tx_q.push_back(exp_q[k]);
    start_burst(4, 8'h02, 8'd0, 8'd1);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (go_cnt == 2) begin ok = 1'b1; break; end
    end
    pulse_abort();
    wait_quiet(300, ok);
    checks++;
    if (!ok || (go_cnt !== 2) || (done_cnt !== 1) || (aborted !== 1'b1)) begin
      errors++;
      $display("FAIL abort_mid got go=%0d done=%0d aborted=%b want 2 1 1", go_cnt, done_cnt, aborted);
    end
    checks++;
    if ((rx_got.size() != 2) || (rx_got[0] !== exp_q[0]) || (rx_got[1] !== exp_q[1])) begin
      errors++; $display("FAIL abort_rx got n=%0d want 2 words", rx_got.size());
    end
    tx_q.delete();

    // Abort while still in setup: no word is ever started.
    clear_obs();
    tx_q.push_back($urandom);
    start_burst(3, 8'h20, 8'd6, 8'd0);
    checks++;
    if (aborted !== 1'b0) begin errors++; $display("FAIL abort_clear got %b want 0", aborted); end
    pulse_abort();
    wait_quiet(100, ok);
    checks++;
    if (!ok || (go_cnt !== 0) || (done_cnt !== 1) || (aborted !== 1'b1) || (ss_n !== 8'hFF)) begin
      errors++;
      $display("FAIL abort_setup got go=%0d done=%0d aborted=%b ss=%h want 0 1 1 ff",
               go_cnt, done_cnt, aborted, ss_n);
    end
    tx_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_obs();
    rx_mode = 0;
    tx_q.push_back($urandom); tx_q.push_back($urandom); tx_q.push_back($urandom);
    start_burst(3, 8'h08, 8'd0, 8'd0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if ((go_cnt == 2) && sh_tip) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || (rx_valid !== 1'b1) || (ss_n !== 8'hF7)) begin
      errors++; $display("FAIL rstmid_pre got rx_valid=%b ss=%h want 1 f7", rx_valid, ss_n);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ((ss_n !== 8'hFF) || (busy !== 1'b0) || (rx_valid !== 1'b0)) begin
      errors++;
      $display("FAIL rstmid_async got ss=%h busy=%b rx_valid=%b want ff 0 0", ss_n, busy, rx_valid);
    end
    tx_q.delete();
    @(negedge clk);
    rst = 1'b0;
    rx_mode = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_words();
    clear_obs();
    start_burst(0, 8'h01, 8'd0, 8'd0);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if ((busy_seen !== 1'b0) || (done_cnt !== 0) || (ss_n !== 8'hFF)) begin
      errors++;
      $display("FAIL zero_words got busy_seen=%b done=%0d ss=%h want 0 0 ff", busy_seen, done_cnt, ss_n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_obs();
    test_reset();
    test_single();
    test_burst();
    test_rx_stall();
    test_tx_gap();
    test_abort();
    test_reset_mid();
    test_zero_words();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
